// File: rtl/fir_decimator_if.sv
// Sample/result stream bundle for fir_decimator.
// Handshake: an input sample is taken on any rising edge where in_en=1
// (there is no backpressure on the input side); a result is transferred
// on a rising edge where out_valid=1 and out_ready=1, and out_ready is
// ignored while out_valid=0.
interface fir_decimator_if;
   logic              in_en;
   logic signed [7:0] input_sig;
   logic signed [7:0] out_sig;
   logic              out_valid;
   logic              out_ready;

   // Producer/consumer side (drives samples, accepts results)
   modport master (
      output in_en, input_sig, out_ready,
      input  out_sig, out_valid
   );

   // Decimator side
   modport slave (
      input  in_en, input_sig, out_ready,
      output out_sig, out_valid
   );
endinterface

// File: rtl/fir_decimator.sv
// Block-average decimator: sums DECIM consecutive enabled samples, emits
// the floored mean, and buffers results in a first-word-fall-through FIFO
// with a sticky overflow flag for results dropped while the FIFO is full.
module fir_decimator #(
   parameter int DECIM = 4,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   fir_decimator_if.slave           bus,
   input  logic                     clr_ovf,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int LD = $clog2(DECIM);
   localparam int AW = 8 + LD;
   localparam int AD = $clog2(DEPTH);
   localparam int FW = AD + 1;

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] sum;
   logic signed [AW-1:0] shifted;
   logic [7:0]           result;
   logic [LD-1:0]        phase;
   logic [7:0]           mem [DEPTH];
   logic [AD-1:0]        wr_ptr;
   logic [AD-1:0]        rd_ptr;
   logic                 push_req;
   logic                 pop;
   logic                 push_ok;
   logic                 discard;

   // Running sum including the current sample and its floored mean;
   // DECIM samples of 8 bits always fit in 8+log2(DECIM) bits.
   always_comb begin
      sum     = acc + {{LD{bus.input_sig[7]}}, bus.input_sig};
      shifted = sum >>> LD;
      result  = shifted[7:0];
   end

   // Push/pop decisions; a full FIFO still accepts a push when it pops on the same edge.
   always_comb begin
      push_req = bus.in_en && (phase == LD'(DECIM - 1));
      pop      = (fill != '0) && bus.out_ready;
      push_ok  = push_req && ((fill != FW'(DEPTH)) || pop);
      discard  = push_req && !push_ok;
   end

   // Accumulator and phase counter advance only on enabled samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         phase <= '0;
      end else if (bus.in_en) begin
         if (phase == LD'(DECIM - 1)) begin
            acc   <= '0;
            phase <= '0;
         end else begin
            acc   <= sum;
            phase <= phase + 1'b1;
         end
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // FIFO storage; contents are only meaningful below fill, so no reset needed.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= result;
   end

   // Sticky overflow; a discard on the same edge as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       overflow <= 1'b0;
      else if (discard) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
   end

   assign bus.out_valid = (fill != '0);
   assign bus.out_sig   = (fill != '0) ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fir_decimator.sv
// Self-checking bench for fir_decimator: directed scenarios plus random
// traffic, checked against a block-mean reference model and a result queue.
module tb_fir_decimator;

   localparam int DECIM = 4;
   localparam int DEPTH = 8;
   localparam int FW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr_ovf = 1'b0;
   logic          overflow;
   logic [FW-1:0] fill;

   fir_decimator_if bus_if ();

   fir_decimator #(.DECIM(DECIM), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus_if),
      .clr_ovf  (clr_ovf),
      .overflow (overflow),
      .fill     (fill)
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard state
   logic [7:0] exp_q[$];
   int         samp_q[$];
   bit         exp_ovf = 1'b0;
   int         n_cmp = 0;
   int         n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: floored mean of each block of DECIM enabled samples
   function automatic logic [7:0] block_mean(input int s);
      int r;
      if (s >= 0) r = s / DECIM;
      else        r = -((-s + DECIM - 1) / DECIM);
      return 8'(r);
   endfunction

   // model update for the coming rising edge (runs after the monitor's pop)
   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         exp_q.delete();
         samp_q.delete();
         exp_ovf = 1'b0;
      end else begin
         bit disc;
         disc = 1'b0;
         if (bus_if.in_en) begin
            samp_q.push_back(int'(bus_if.input_sig));
            if (samp_q.size() == DECIM) begin
               int s;
               s = 0;
               foreach (samp_q[i]) s += samp_q[i];
               samp_q.delete();
               if (exp_q.size() < DEPTH) exp_q.push_back(block_mean(s));
               else                      disc = 1'b1;
            end
         end
         if (disc)         exp_ovf = 1'b1;
         else if (clr_ovf) exp_ovf = 1'b0;
      end
   end

   // monitor: compare visible state, then retire the head if it is consumed
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_fill", int'(fill), 0);
         chk("rst_valid", int'(bus_if.out_valid), 0);
         chk("rst_sig", int'(bus_if.out_sig), 0);
         chk("rst_ovf", int'(overflow), 0);
      end else begin
         chk("fill", int'(fill), exp_q.size());
         chk("out_valid", int'(bus_if.out_valid), int'(exp_q.size() != 0));
         chk("out_sig", int'($signed(bus_if.out_sig)),
             (exp_q.size() != 0) ? int'($signed(exp_q[0])) : 0);
         chk("overflow", int'(overflow), int'(exp_ovf));
         if (exp_q.size() != 0 && bus_if.out_ready) void'(exp_q.pop_front());
      end
   end

   // driver tasks
   task automatic cycle(input bit en, input logic [7:0] s, input bit rdy, input bit clr);
      @(posedge clk);
      #1;
      bus_if.in_en     = en;
      bus_if.input_sig = s;
      bus_if.out_ready = rdy;
      clr_ovf          = clr;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy, 1'b0);
   endtask

   task automatic send4(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
      cycle(1'b1, a, 1'b1, 1'b0);
      cycle(1'b1, b, 1'b1, 1'b0);
      cycle(1'b1, c, 1'b1, 1'b0);
      cycle(1'b1, d, 1'b1, 1'b0);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst_n        = 1'b0;
      bus_if.in_en = 1'b0;
      #1;
      chk("async_rst_fill", int'(fill), 0);
      chk("async_rst_valid", int'(bus_if.out_valid), 0);
      chk("async_rst_sig", int'(bus_if.out_sig), 0);
      chk("async_rst_ovf", int'(overflow), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus_if.in_en     = 1'b0;
      bus_if.input_sig = '0;
      bus_if.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // constant 20 with a ready consumer
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'd20, 1'b1, 1'b0);
      idle(3, 1'b1);

      // rounding and extremes
      send4(8'hFF, 8'hFF, 8'hFF, 8'hFE);
      send4(8'h80, 8'h80, 8'h80, 8'h80);
      send4(8'h7F, 8'h7F, 8'h7F, 8'h7F);
      send4(8'h81, 8'h7F, 8'h00, 8'hFF);
      idle(3, 1'b1);

      // fill the FIFO, drop the 9th result, drain, then clear overflow
      for (int i = 0; i < 9 * DECIM; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      idle(2, 1'b0);
      idle(DEPTH + 2, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      idle(2, 1'b1);

      // full FIFO with push and pop on the same edge
      for (int i = 0; i < DEPTH * DECIM; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      for (int i = 0; i < DECIM - 1; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      idle(1, 1'b0);
      idle(DEPTH + 2, 1'b1);

      // gapped input stream
      for (int i = 0; i < 2 * DECIM; i++) begin
         cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
         cycle(1'b0, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      end
      idle(2, 1'b1);

      // reset mid-accumulation and with stored results
      cycle(1'b1, 8'd100, 1'b0, 1'b0);
      cycle(1'b1, 8'd50, 1'b0, 1'b0);
      pulse_reset();
      send4(8'd8, 8'd9, 8'hF0, 8'd3);
      idle(2, 1'b1);
      for (int i = 0; i < 2 * DECIM + 2; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      pulse_reset();
      send4(8'd1, 8'd2, 8'd3, 8'd4);
      idle(2, 1'b1);

      // random traffic: slow consumer first, then a faster one
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
               (i < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0),
               $urandom_range(0, 15) == 0);
      end
      idle(DEPTH + 4, 1'b1);

      @(negedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 Parameter DECIM, default 4: decimation ratio; power of 2, range 2..64.
REQ-002 Parameter DEPTH, default 8: output FIFO depth in results; power of 2, range 2..64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_en  input  1  input_sig holds a valid FIR output sample this cycle.
REQ-006 input_sig  input  8  signed two's-complement sample from the upstream FIR filter.
REQ-007 out_sig  output  8  signed decimated result at the FIFO head.
REQ-008 out_valid  output  1  out_sig holds a valid result.
REQ-009 out_ready  input  1  consumer accepts out_sig this cycle.
REQ-010 overflow  output  1  sticky flag; a result was discarded because the FIFO was full.
REQ-011 clr_ovf  input  1  synchronous clear of overflow.
REQ-012 fill  output  log2(DEPTH)+1  number of results held in the FIFO, 0..DEPTH.

Function
REQ-013 Edge with in_en=1: add input_sig, sign-extended, to an accumulator of width 8+log2(DECIM) and advance phase counter 0..DECIM-1.
REQ-014 Edge with in_en=0: accumulator and phase hold; no other input-side effect.
REQ-015 Edge with in_en=1 and phase=DECIM-1: form result = (acc + input_sig) >>> log2(DECIM) (arithmetic shift, floor toward -inf; always fits 8 bits); clear accumulator to 0; set phase to 0; issue a push.
REQ-016 Result latency: the result is visible on out_sig with out_valid=1 in the cycle after the edge completing its DECIM-th sample, provided the FIFO was empty.
REQ-017 FIFO is first-word-fall-through: out_valid = (fill != 0); out_sig = oldest stored result; out_sig = 0 when fill = 0.
REQ-018 Pop occurs on an edge with out_valid=1 and out_ready=1; out_sig then shows the next result, or 0 if none remain.
REQ-019 Push is accepted when fill < DEPTH, or when fill = DEPTH and a pop occurs on the same edge.
REQ-020 Simultaneous accepted push and pop: fill unchanged; ordering preserved.
REQ-021 Push not accepted: result discarded; FIFO contents and fill unchanged; overflow = 1 from the next cycle.
REQ-022 overflow holds 1 until an edge with clr_ovf=1 and no new discard; if a discard and clr_ovf occur on the same edge, overflow stays 1 (set wins).
REQ-023 Results leave the FIFO in production order; FIFO pointer wrap-around is invisible at the ports.
REQ-024 out_ready is ignored while out_valid=0; popping an empty FIFO is impossible.

Reset
REQ-025 rst_n=0 immediately forces accumulator=0, phase=0, fill=0, out_valid=0, out_sig=0, overflow=0, independent of clk.
REQ-026 Reset asserted mid-accumulation or with a non-empty FIFO discards the partial sum and all stored results.
REQ-027 After rst_n rises, the first result requires DECIM fresh in_en samples.

Verification
REQ-028 DECIM=4, input_sig=20, in_en=1 every cycle, out_ready=1 -> out_valid=1 one cycle after the 4th sample edge, out_sig=20; one result every 4 cycles; fill never exceeds 1.
REQ-029 Samples -1,-1,-1,-2 -> out_sig=-2; four samples of -128 -> -128; four samples of 127 -> 127.
REQ-030 out_ready=0, DEPTH=8, 9 results produced -> fill=8, 9th result dropped, overflow=1; then out_ready=1 -> first 8 results drained in order; clr_ovf=1 -> overflow=0.
REQ-031 fill=8, push and pop on the same edge -> no discard, overflow stays 0, fill stays 8, new result lands at tail.
REQ-032 in_en pattern 1,0,1,0,... over 8 samples -> results identical to the same samples presented contiguously.
REQ-033 rst_n pulsed low after 2 of 4 samples -> all outputs 0 immediately; after release, the first result appears only after 4 new samples and equals their floored mean.
